// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the unbuffered ALU
// writeback stage and a FIFO of long-latency results, with starvation relief.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_stall,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_data,
    output logic [4:0]               A3,
    output logic [31:0]              WD3,
    output logic                     RegWrite,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    wait_cnt;

    logic full;
    logic empty;
    logic enq;
    logic deq;
    logic force_drain;
    logic alu_write;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign lsu_ready   = !full;
    // x0 results complete the handshake but are never stored
    assign enq         = lsu_valid && !full && (lsu_rd != 5'd0);
    assign force_drain = !empty && (wait_cnt == 8'(STARVE_LIMIT));
    assign fifo_count  = count;

    // Gated by RESET so an in-flight ALU request cannot write while held in reset
    always_comb begin
        RegWrite  = 1'b0;
        A3        = 5'd0;
        WD3       = 32'd0;
        alu_stall = 1'b0;
        deq       = 1'b0;
        alu_write = 1'b0;
        if (RESET) begin
            if (force_drain) begin
                RegWrite  = 1'b1;
                A3        = mem_rd[rd_ptr];
                WD3       = mem_data[rd_ptr];
                deq       = 1'b1;
                alu_stall = alu_valid;
            end else if (alu_valid && (alu_rd != 5'd0)) begin
                RegWrite  = 1'b1;
                A3        = alu_rd;
                WD3       = alu_data;
                alu_write = 1'b1;
            end else if (!empty) begin
                RegWrite  = 1'b1;
                A3        = mem_rd[rd_ptr];
                WD3       = mem_data[rd_ptr];
                deq       = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= 8'd0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (deq || empty) begin
                wait_cnt <= 8'd0;
            end else if (alu_write && (wait_cnt != 8'(STARVE_LIMIT))) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_rd[wr_ptr]   <= lsu_rd;
            mem_data[wr_ptr] <= lsu_data;
        end
    end

    // Walk only the occupied slots so duplicates keep their bit until the last drains
    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                pend_mask[mem_rd[rd_ptr + PW'(i)]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a queue-based
// model of the write-port arbitration rules.
module tb_rf_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 7;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic        CLK;
    logic        RESET;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        RegWrite;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    entry_t      q[$];
    int          waitc = 0;
    logic        stallPending = 1'b0;
    logic        heldAv = 1'b0;
    logic [4:0]  heldRd = 5'd0;
    logic [31:0] heldData = 32'd0;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .A3(A3), .WD3(WD3), .RegWrite(RegWrite),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive, check mid-cycle against the model, then advance the model at the edge
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        int          n;
        logic        expReady, expWrite, expStall, deq, aluWrote;
        logic [4:0]  expA3;
        logic [31:0] expWd, expMask;
        if (stallPending) begin
            av    = heldAv;
            ard   = heldRd;
            adata = heldData;
        end
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adata;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ldata;
        @(negedge CLK);
        n        = q.size();
        expReady = (n != DEPTH);
        expWrite = 1'b0;
        expA3    = 5'd0;
        expWd    = 32'd0;
        expStall = 1'b0;
        deq      = 1'b0;
        aluWrote = 1'b0;
        if (n != 0 && waitc == LIMIT) begin
            expWrite = 1'b1; expA3 = q[0].rd; expWd = q[0].data; deq = 1'b1; expStall = av;
        end else if (av && ard != 5'd0) begin
            expWrite = 1'b1; expA3 = ard; expWd = adata; aluWrote = 1'b1;
        end else if (n != 0) begin
            expWrite = 1'b1; expA3 = q[0].rd; expWd = q[0].data; deq = 1'b1;
        end
        expMask = 32'd0;
        foreach (q[i]) expMask[q[i].rd] = 1'b1;
        checkOutput("RegWrite", {31'd0, RegWrite}, {31'd0, expWrite});
        checkOutput("A3", {27'd0, A3}, {27'd0, expA3});
        checkOutput("WD3", WD3, expWd);
        checkOutput("alu_stall", {31'd0, alu_stall}, {31'd0, expStall});
        checkOutput("lsu_ready", {31'd0, lsu_ready}, {31'd0, expReady});
        checkOutput("pend_mask", pend_mask, expMask);
        checkOutput("fifo_count", {29'd0, fifo_count}, n);
        checkOutput("x0_write", {31'd0, RegWrite && (A3 == 5'd0)}, 32'd0);
        @(posedge CLK);
        if (deq) void'(q.pop_front());
        if (lv && expReady && lrd != 5'd0) q.push_back('{lrd, ldata});
        if (deq || n == 0) waitc = 0;
        else if (aluWrote && waitc < LIMIT) waitc++;
        stallPending = expStall;
        heldAv   = av;
        heldRd   = ard;
        heldData = adata;
        #1;
    endtask

    // Asserts RESET between edges and checks the outputs respond without a clock
    task automatic applyReset();
        #2;
        RESET     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        checkOutput("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("rst_A3", {27'd0, A3}, 32'd0);
        checkOutput("rst_WD3", WD3, 32'd0);
        checkOutput("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
        checkOutput("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        checkOutput("rst_pend_mask", pend_mask, 32'd0);
        checkOutput("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        q.delete();
        waitc        = 0;
        stallPending = 1'b0;
        #3;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        lsu_valid = 1'b0;
        lsu_rd    = 5'd0;
        lsu_data  = 32'd0;
        @(posedge CLK);
        #1;
        applyReset();

        // Idle drain of a single result
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd3, 32'hDEADBEEF);
        idle(2);

        // ALU priority while the FIFO fills, then periodic forced drains
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'd1, $urandom, 1, 5'(8 + i), $urandom);
        for (int i = 0; i < 26; i++) applyStimulus(1, 5'd1, $urandom, 1, 5'(12 + (i % 4)), $urandom);
        idle(6);

        // x0 handling on both sources
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
        applyStimulus(1, 5'd1, 32'h11, 1, 5'd4, 32'h44);
        applyStimulus(1, 5'd0, 32'h99, 0, 5'd0, 32'd0);
        idle(2);

        // Build count=3 under ALU pressure, then enqueue+dequeue together while idle
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'd2, $urandom, 1, 5'(20 + i), $urandom);
        for (int i = 0; i < 6; i++) applyStimulus(0, 5'd0, 32'd0, 1, 5'(24 + i), $urandom);
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'd2, $urandom, 1, 5'(7 + i), $urandom);
        for (int i = 0; i < 4; i++) applyStimulus(0, 5'd0, 32'd0, 1, 5'(16 + i), $urandom);
        idle(5);

        // Reset mid-queue: x5 and x6 must never be written afterwards
        applyStimulus(1, 5'd1, 32'h1, 1, 5'd5, 32'h55);
        applyStimulus(1, 5'd1, 32'h2, 1, 5'd6, 32'h66);
        applyReset();
        idle(4);

        // Random traffic with small rd range for duplicate destinations
        for (int i = 0; i < 1500; i++) begin
            logic        av, lv;
            logic [4:0]  ard, lrd;
            av  = ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 8 : 3));
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lv  = ($urandom_range(0, 2) != 0);
            lrd = 5'($urandom_range(0, 7));
            applyStimulus(av, ard, $urandom, lv, lrd, $urandom);
            if (i == 900) applyReset();
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
